// File: rtl/vram_slot_arbiter.sv
// Time-slices the single-port VRAM between scanout (fixed slot each visible pixel) and the CPU port.
// Optional macro VRAM_ARB_WBUF_EN adds a one-entry posted write buffer on the CPU side.
module vram_slot_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clk_50,
    input  logic              rst,
    input  logic              vga_clk,
    input  logic              in_display_area,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata
);

    typedef enum logic {IDLE, RD_WAIT} cpu_state_t;

    cpu_state_t state;
    cpu_state_t state_next;

    logic display_slot;
    logic cpu_slot;
    logic issue_rd;
    logic ack_now;
    logic [ADDR_W-1:0] addr_next;
    logic              we_next;
    logic [DATA_W-1:0] wdata_next;

    // Read-return tags, aligned with the RAM's one-cycle latency plus the output register.
    logic disp_rd_1, disp_rd_2;
    logic cpu_rd_1, cpu_rd_2;

    assign display_slot = !vga_clk && in_display_area;
    assign cpu_slot     = !display_slot;

`ifdef VRAM_ARB_WBUF_EN
    logic              wbuf_valid;
    logic [ADDR_W-1:0] wbuf_addr;
    logic [DATA_W-1:0] wbuf_data;
    logic              accept_wr;
    logic              drain;

    always_comb begin
        accept_wr  = (state == IDLE) && !wbuf_valid && cpu_req && cpu_we;
        drain      = wbuf_valid && cpu_slot;
        // Reads wait for the buffer to drain so read-after-write sees the new data.
        issue_rd   = (state == IDLE) && !wbuf_valid && cpu_req && !cpu_we && cpu_slot;
        ack_now    = accept_wr || issue_rd;
        addr_next  = vram_addr;
        we_next    = 1'b0;
        wdata_next = vram_wdata;
        if (display_slot) begin
            addr_next = disp_addr;
        end else if (drain) begin
            addr_next  = wbuf_addr;
            we_next    = 1'b1;
            wdata_next = wbuf_data;
        end else if (issue_rd) begin
            addr_next = cpu_addr;
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            wbuf_valid <= 1'b0;
            wbuf_addr  <= '0;
            wbuf_data  <= '0;
        end else if (accept_wr) begin
            wbuf_valid <= 1'b1;
            wbuf_addr  <= cpu_addr;
            wbuf_data  <= cpu_wdata;
        end else if (drain) begin
            wbuf_valid <= 1'b0;
        end
    end
`else
    logic issue_cpu;

    always_comb begin
        issue_cpu  = (state == IDLE) && cpu_req && cpu_slot;
        issue_rd   = issue_cpu && !cpu_we;
        ack_now    = issue_cpu;
        addr_next  = vram_addr;
        we_next    = 1'b0;
        wdata_next = vram_wdata;
        if (display_slot) begin
            addr_next = disp_addr;
        end else if (issue_cpu) begin
            addr_next  = cpu_addr;
            we_next    = cpu_we;
            wdata_next = cpu_wdata;
        end
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue_rd) state_next = RD_WAIT;
            RD_WAIT: if (cpu_rd_2) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state      <= IDLE;
            vram_addr  <= '0;
            vram_we    <= 1'b0;
            vram_wdata <= '0;
            cpu_ack    <= 1'b0;
            disp_rd_1  <= 1'b0;
            disp_rd_2  <= 1'b0;
            cpu_rd_1   <= 1'b0;
            cpu_rd_2   <= 1'b0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
        end else begin
            state      <= state_next;
            vram_addr  <= addr_next;
            vram_we    <= we_next;
            vram_wdata <= wdata_next;
            cpu_ack    <= ack_now;
            disp_rd_1  <= display_slot;
            disp_rd_2  <= disp_rd_1;
            cpu_rd_1   <= issue_rd;
            cpu_rd_2   <= cpu_rd_1;
            disp_valid <= disp_rd_2;
            cpu_rvalid <= cpu_rd_2;
            if (disp_rd_2) disp_data <= vram_rdata;
            if (cpu_rd_2) cpu_rdata <= vram_rdata;
        end
    end

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Directed bench for vram_slot_arbiter: cycle table plus hand sequences for exit, reset and write buffer.
module tb_vram_slot_arbiter;

    logic        clk;
    logic        rst;
    logic        vga_clk;
    logic        in_display_area;
    logic [13:0] disp_addr;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic [13:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic        preload;

    int checks;
    int failures;

    vram_slot_arbiter #(.ADDR_W(14), .DATA_W(8)) dut (
        .clk_50(clk),
        .rst(rst),
        .vga_clk(vga_clk),
        .in_display_area(in_display_area),
        .disp_addr(disp_addr),
        .disp_data(disp_data),
        .disp_valid(disp_valid),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .vram_addr(vram_addr),
        .vram_we(vram_we),
        .vram_wdata(vram_wdata),
        .vram_rdata(vram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous single-port RAM, one-cycle read latency; scanout region preloaded with 0x30+i.
    logic [7:0] mem [0:16383];
    always @(posedge clk) begin
        if (preload) begin
            for (int j = 0; j < 8; j++) mem[14'h0100 + 14'(j)] <= 8'h30 + 8'(j);
        end else if (vram_we) begin
            mem[vram_addr] <= vram_wdata;
        end
        vram_rdata <= mem[vram_addr];
    end

    typedef struct packed {
        logic        da;
        logic [13:0] daddr;
        logic        req;
        logic        we;
        logic [13:0] addr;
        logic [7:0]  wd;
        logic        e_ack;
        logic        e_vwe;
        logic [13:0] e_vaddr;
        logic        e_rv;
        logic [7:0]  e_rd;
        logic        e_dv;
        logic [7:0]  e_dd;
    } vec_t;

    vec_t vecs [17];

    task automatic tick();
        @(posedge clk);
        #1;
        vga_clk = ~vga_clk;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cpu_read(input logic [13:0] a, input logic [7:0] exp, input string name);
        logic got;
        got = 1'b0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = a;
        for (int n = 0; n < 8 && !got; n++) begin
            tick();
            if (cpu_ack) got = 1'b1;
        end
        cpu_req = 1'b0;
        check({name, "_ack"}, 32'(got), 32'd1);
        if (got) begin
            tick();
            check({name, "_rvalid_early"}, 32'(cpu_rvalid), 32'd0);
            tick();
            check({name, "_rvalid"}, 32'(cpu_rvalid), 32'd1);
            check({name, "_rdata"}, 32'(cpu_rdata), 32'(exp));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        preload = 1'b1;
        vga_clk = 1'b0;
        in_display_area = 1'b0;
        disp_addr = '0;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;

        //           da daddr    req we addr     wd    | ack vwe vaddr   rv rd     dv dd
        vecs[0]  = '{1'b0, 14'h0000, 1'b1, 1'b1, 14'h0123, 8'hA5, 1'b1, 1'b1, 14'h0123, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 14'h0000, 1'b1, 1'b0, 14'h0123, 8'h00, 1'b1, 1'b0, 14'h0123, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 14'h0000, 1'b1, 1'b1, 14'h0200, 8'h11, 1'b0, 1'b0, 14'h0123, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 14'h0000, 1'b1, 1'b1, 14'h0200, 8'h11, 1'b0, 1'b0, 14'h0123, 1'b1, 8'hA5, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 14'h0000, 1'b1, 1'b1, 14'h0200, 8'h11, 1'b1, 1'b1, 14'h0200, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 14'h0000, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0, 1'b0, 14'h0200, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 14'h0100, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0, 1'b0, 14'h0100, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 14'h0100, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0, 1'b0, 14'h0100, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[8]  = '{1'b1, 14'h0101, 1'b1, 1'b1, 14'h0300, 8'h77, 1'b0, 1'b0, 14'h0101, 1'b0, 8'h00, 1'b1, 8'h30};
        vecs[9]  = '{1'b1, 14'h0101, 1'b1, 1'b1, 14'h0300, 8'h77, 1'b1, 1'b1, 14'h0300, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[10] = '{1'b1, 14'h0102, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0, 1'b0, 14'h0102, 1'b0, 8'h00, 1'b1, 8'h31};
        vecs[11] = '{1'b1, 14'h0102, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0, 1'b0, 14'h0102, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[12] = '{1'b1, 14'h0103, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0, 1'b0, 14'h0103, 1'b0, 8'h00, 1'b1, 8'h32};
        vecs[13] = '{1'b1, 14'h0103, 1'b1, 1'b0, 14'h0300, 8'h00, 1'b1, 1'b0, 14'h0300, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[14] = '{1'b1, 14'h0104, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0, 1'b0, 14'h0104, 1'b0, 8'h00, 1'b1, 8'h33};
        vecs[15] = '{1'b1, 14'h0104, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0, 1'b0, 14'h0104, 1'b1, 8'h77, 1'b0, 8'h00};
        vecs[16] = '{1'b1, 14'h0105, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0, 1'b0, 14'h0105, 1'b0, 8'h00, 1'b1, 8'h34};

        tick();
        preload = 1'b0;
        tick();
        check("rst_vram_addr", 32'(vram_addr), 32'd0);
        check("rst_vram_we", 32'(vram_we), 32'd0);
        check("rst_vram_wdata", 32'(vram_wdata), 32'd0);
        check("rst_disp_data", 32'(disp_data), 32'd0);
        check("rst_disp_valid", 32'(disp_valid), 32'd0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        rst = 1'b0;
        vga_clk = 1'b0;

`ifndef VRAM_ARB_WBUF_EN
        // Cycle-exact table: vga_clk is 0 on even rows, 1 on odd rows.
        for (int i = 0; i < 17; i++) begin
            in_display_area = vecs[i].da;
            disp_addr = vecs[i].daddr;
            cpu_req = vecs[i].req;
            cpu_we = vecs[i].we;
            cpu_addr = vecs[i].addr;
            cpu_wdata = vecs[i].wd;
            tick();
            check($sformatf("row%0d_ack", i), 32'(cpu_ack), 32'(vecs[i].e_ack));
            check($sformatf("row%0d_vram_we", i), 32'(vram_we), 32'(vecs[i].e_vwe));
            check($sformatf("row%0d_vram_addr", i), 32'(vram_addr), 32'(vecs[i].e_vaddr));
            check($sformatf("row%0d_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].e_rv));
            check($sformatf("row%0d_disp_valid", i), 32'(disp_valid), 32'(vecs[i].e_dv));
            if (vecs[i].e_rv) check($sformatf("row%0d_rdata", i), 32'(cpu_rdata), 32'(vecs[i].e_rd));
            if (vecs[i].e_dv) check($sformatf("row%0d_disp_data", i), 32'(disp_data), 32'(vecs[i].e_dd));
        end
        in_display_area = 1'b0;
        disp_addr = '0;
        cpu_req = 1'b0;

        // Display-area exit with four back-to-back writes queued in the last display slot.
        if (vga_clk) tick();
        in_display_area = 1'b1;
        disp_addr = 14'h0100;
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 14'h3FFC;
        cpu_wdata = 8'hC0;
        tick();
        check("exit_wait_ack", 32'(cpu_ack), 32'd0);
        in_display_area = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("exit%0d_ack", i), 32'(cpu_ack), 32'd1);
            check($sformatf("exit%0d_vram_we", i), 32'(vram_we), 32'd1);
            check($sformatf("exit%0d_vram_addr", i), 32'(vram_addr), 32'h3FFC + 32'(i));
            if (i < 3) begin
                cpu_addr = 14'h3FFC + 14'(i + 1);
                cpu_wdata = 8'hC1 + 8'(i);
            end
        end
        cpu_req = 1'b0;
        tick();
        tick();
        cpu_read(14'h3FFC, 8'hC0, "rb_3ffc");
        cpu_read(14'h3FFD, 8'hC1, "rb_3ffd");
        cpu_read(14'h3FFE, 8'hC2, "rb_3ffe");
        cpu_read(14'h3FFF, 8'hC3, "rb_3fff");
        cpu_read(14'h0300, 8'h77, "rb_0300");

        // Reset one cycle after a read ack: the read must vanish.
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 14'h3FFE;
        tick();
        check("rstrd_ack", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstrd_vram_addr", 32'(vram_addr), 32'd0);
        check("rstrd_vram_we", 32'(vram_we), 32'd0);
        check("rstrd_vram_wdata", 32'(vram_wdata), 32'd0);
        check("rstrd_disp_data", 32'(disp_data), 32'd0);
        check("rstrd_disp_valid", 32'(disp_valid), 32'd0);
        check("rstrd_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rstrd_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rstrd_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rstrd_no_rvalid%0d", i), 32'(cpu_rvalid), 32'd0);
        end
        cpu_read(14'h3FFD, 8'hC1, "post_rst_read");
`else
        // Posted write in a display slot is acked at once; read-after-write sees it.
        if (vga_clk) tick();
        in_display_area = 1'b1;
        disp_addr = 14'h0100;
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 14'h0040;
        cpu_wdata = 8'h5A;
        tick();
        check("wbuf_ack", 32'(cpu_ack), 32'd1);
        check("wbuf_display_we", 32'(vram_we), 32'd0);
        check("wbuf_display_addr", 32'(vram_addr), 32'h0100);
        cpu_req = 1'b0;
        cpu_read(14'h0040, 8'h5A, "wbuf_raw");
        in_display_area = 1'b0;
        cpu_read(14'h0101, 8'h31, "wbuf_plain");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
